// File: rtl/sc_fifo_ext_if.sv
// rtl/sc_fifo_ext_if.sv - Handshake bundle between a FIFO user and sc_fifo_ext
//
// Ports (as seen by the FIFO, slave modport):
//   flush_i         in   synchronous clear of contents
//   wr_en_i         in   write request
//   data_i          in   write data, DATA_W bits
//   rd_en_i         in   read request / head acknowledge in show-ahead mode
//   data_o          out  read data, DATA_W bits
//   usedw_o         out  stored word count, ADDR_W+1 bits
//   empty_o         out  no readable word
//   full_o          out  every entry occupied
//   almost_full_o   out  usedw_o at or above the almost-full level
//   almost_empty_o  out  usedw_o at or below the almost-empty level
//   overflow_o      out  one-cycle pulse for a rejected write
//   underflow_o     out  one-cycle pulse for a rejected read
interface sc_fifo_ext_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              flush_i;
  logic              wr_en_i;
  logic [DATA_W-1:0] data_i;
  logic              rd_en_i;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W:0]   usedw_o;
  logic              empty_o;
  logic              full_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              overflow_o;
  logic              underflow_o;

  // Producer/consumer side.
  modport master (
    output flush_i, wr_en_i, data_i, rd_en_i,
    input  data_o, usedw_o, empty_o, full_o, almost_full_o, almost_empty_o,
           overflow_o, underflow_o
  );

  // FIFO side.
  modport slave (
    input  flush_i, wr_en_i, data_i, rd_en_i,
    output data_o, usedw_o, empty_o, full_o, almost_full_o, almost_empty_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/sc_fifo_ext.sv
// rtl/sc_fifo_ext.sv - Single-clock FIFO with show-ahead option, level flags and error pulses
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_n_i  in   synchronous active-low reset
//   bus      slave modport of sc_fifo_ext_if (flush, write, read, data, status flags)
module sc_fifo_ext #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int SHOWAHEAD = 0,
  parameter int AF_LEVEL  = 2**ADDR_W - 4,
  parameter int AE_LEVEL  = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  sc_fifo_ext_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_C    = cnt_t'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_q;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t usedw_q, usedw_d;
  logic empty_q, empty_d;
  logic full_q, full_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  logic rd_acc;
  logic wr_acc;
  logic wr_fire;
  logic ld_mem;
  logic ld_in;
  ptr_t raddr;

  // Request qualification. A read is judged against the registered state
  // only, so a write landing in an empty FIFO cannot satisfy a read in the
  // same cycle. A write at full is accepted when a read frees a slot.
  always_comb begin
    rd_acc  = bus.rd_en_i && !empty_q;
    wr_acc  = bus.wr_en_i && (!full_q || rd_acc);
    wr_fire = wr_acc && !bus.flush_i;
  end

  // Pointer, count and flag next-state. Flags come from usedw_d so they
  // always agree with usedw_o on the same edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;

    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   usedw_d = usedw_q + cnt_t'(1);
        2'b01:   usedw_d = usedw_q - cnt_t'(1);
        default: usedw_d = usedw_q;
      endcase
      ovf_d = bus.wr_en_i && !wr_acc;
      unf_d = bus.rd_en_i && empty_q;
    end

    empty_d = (usedw_d == '0);
    full_d  = (usedw_d == DEPTH_C);
    af_d    = (usedw_d >= AF_C);
    ae_d    = (usedw_d <= AE_C);
  end

  // Output-register load selection.
  // Normal mode: the head entry is read out on the accepted read's edge.
  // Show-ahead mode: the output register always holds the head word. It is
  // loaded straight from data_i when the incoming word becomes the head
  // (write into empty, or read+write with one word stored, where the new word
  // is not in the array yet); otherwise the next head is read from rd_ptr+1,
  // which was written on an earlier edge. When the last word is consumed
  // without a write, data_o holds.
  always_comb begin
    ld_mem = 1'b0;
    ld_in  = 1'b0;
    raddr  = rd_ptr_q;
    if (!bus.flush_i) begin
      if (SHOWAHEAD != 0) begin
        if (rd_acc) begin
          if (usedw_q == cnt_t'(1)) begin
            ld_in = wr_acc;
          end else begin
            ld_mem = 1'b1;
            raddr  = rd_ptr_q + ptr_t'(1);
          end
        end else if (empty_q) begin
          ld_in = wr_acc;
        end
      end else begin
        ld_mem = rd_acc;
      end
    end
  end

  // Storage array: write port plus registered read, no reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_fire) begin
      mem[wr_ptr_q] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
    end else if (ld_mem) begin
      data_q <= mem[raddr];
    end else if (ld_in) begin
      data_q <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.data_o         = data_q;
  assign bus.usedw_o        = usedw_q;
  assign bus.empty_o        = empty_q;
  assign bus.full_o         = full_q;
  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;

endmodule

// File: tb/tb_sc_fifo_ext.sv
// tb/tb_sc_fifo_ext.sv - Directed self-checking bench for sc_fifo_ext
module tb_sc_fifo_ext;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sc_fifo_ext_if #(.DATA_W(8), .ADDR_W(4)) nif ();
  sc_fifo_ext_if #(.DATA_W(8), .ADDR_W(4)) sif ();

  sc_fifo_ext #(
    .DATA_W(8), .ADDR_W(4), .SHOWAHEAD(0), .AF_LEVEL(12), .AE_LEVEL(4)
  ) u_norm (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (nif)
  );

  sc_fifo_ext #(
    .DATA_W(8), .ADDR_W(4), .SHOWAHEAD(1), .AF_LEVEL(12), .AE_LEVEL(4)
  ) u_show (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_n(input string tag);
    check({tag, " n.data"},  32'(nif.data_o), 32'h0);
    check({tag, " n.usedw"}, 32'(nif.usedw_o), 32'd0);
    check({tag, " n.empty"}, 32'(nif.empty_o), 32'd1);
    check({tag, " n.full"},  32'(nif.full_o), 32'd0);
    check({tag, " n.af"},    32'(nif.almost_full_o), 32'd0);
    check({tag, " n.ae"},    32'(nif.almost_empty_o), 32'd1);
    check({tag, " n.ovf"},   32'(nif.overflow_o), 32'd0);
    check({tag, " n.unf"},   32'(nif.underflow_o), 32'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] last_n;
  bit         do_wr;
  bit         do_rd;
  int         wcnt;
  int         rcnt;
  int         iter;

  initial begin
    checks = 0;
    errors = 0;
    nif.flush_i = 1'b0; nif.wr_en_i = 1'b0; nif.rd_en_i = 1'b0; nif.data_i = '0;
    sif.flush_i = 1'b0; sif.wr_en_i = 1'b0; sif.rd_en_i = 1'b0; sif.data_i = '0;

    // Reset, with a write request in the reset cycle that must be ignored.
    rst_n = 1'b0;
    nif.wr_en_i = 1'b1; nif.data_i = 8'h99;
    step();
    nif.wr_en_i = 1'b0;
    rst_n = 1'b1;
    check_reset_n("reset");
    check("reset s.data",  32'(sif.data_o), 32'h0);
    check("reset s.empty", 32'(sif.empty_o), 32'd1);
    step();
    check("reset wr ignored", 32'(nif.usedw_o), 32'd0);

    // Basic normal-mode write 1..5, read back.
    for (int i = 1; i <= 5; i++) begin
      nif.wr_en_i = 1'b1; nif.data_i = 8'(i);
      step();
      check("basic wr usedw", 32'(nif.usedw_o), 32'(i));
      check("basic wr empty", 32'(nif.empty_o), 32'd0);
    end
    nif.wr_en_i = 1'b0;
    check("basic ae at 5", 32'(nif.almost_empty_o), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      nif.rd_en_i = 1'b1;
      step();
      check("basic rd data", 32'(nif.data_o), 32'(i));
      check("basic rd usedw", 32'(nif.usedw_o), 32'(5 - i));
    end
    nif.rd_en_i = 1'b0;
    check("basic empty", 32'(nif.empty_o), 32'd1);

    // Fill to full, one rejected write, then read+write at full.
    for (int i = 0; i < 17; i++) begin
      nif.wr_en_i = 1'b1; nif.data_i = 8'(8'h10 + i);
      step();
      if (i < 16) begin
        check("fill usedw", 32'(nif.usedw_o), 32'(i + 1));
        check("fill af", 32'(nif.almost_full_o), 32'((i + 1) >= 12));
        check("fill full", 32'(nif.full_o), 32'((i + 1) == 16));
        check("fill ovf", 32'(nif.overflow_o), 32'd0);
      end else begin
        check("ovf pulse", 32'(nif.overflow_o), 32'd1);
        check("ovf usedw", 32'(nif.usedw_o), 32'd16);
      end
    end
    nif.wr_en_i = 1'b0;
    step();
    check("ovf one cycle", 32'(nif.overflow_o), 32'd0);
    nif.wr_en_i = 1'b1; nif.rd_en_i = 1'b1; nif.data_i = 8'hEE;
    step();
    nif.wr_en_i = 1'b0;
    check("rdwr full data", 32'(nif.data_o), 32'h10);
    check("rdwr full usedw", 32'(nif.usedw_o), 32'd16);
    check("rdwr full full", 32'(nif.full_o), 32'd1);
    check("rdwr full ovf", 32'(nif.overflow_o), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step();
      check("drain data", 32'(nif.data_o), (i < 16) ? 32'(8'h10 + i) : 32'hEE);
    end
    nif.rd_en_i = 1'b0;
    check("drain empty", 32'(nif.empty_o), 32'd1);

    // Read while empty with a same-cycle write.
    nif.wr_en_i = 1'b1; nif.rd_en_i = 1'b1; nif.data_i = 8'h77;
    step();
    nif.wr_en_i = 1'b0; nif.rd_en_i = 1'b0;
    check("unf pulse", 32'(nif.underflow_o), 32'd1);
    check("unf usedw", 32'(nif.usedw_o), 32'd1);
    check("unf data held", 32'(nif.data_o), 32'hEE);
    step();
    check("unf one cycle", 32'(nif.underflow_o), 32'd0);
    nif.rd_en_i = 1'b1;
    step();
    nif.rd_en_i = 1'b0;
    check("unf rd data", 32'(nif.data_o), 32'h77);
    check("unf rd usedw", 32'(nif.usedw_o), 32'd0);

    // Show-ahead behaviour.
    sif.wr_en_i = 1'b1; sif.data_i = 8'hA5;
    step();
    sif.wr_en_i = 1'b0;
    check("sa first empty", 32'(sif.empty_o), 32'd0);
    check("sa first data", 32'(sif.data_o), 32'hA5);
    sif.wr_en_i = 1'b1; sif.data_i = 8'hB6;
    step();
    sif.wr_en_i = 1'b0;
    check("sa head held", 32'(sif.data_o), 32'hA5);
    check("sa usedw 2", 32'(sif.usedw_o), 32'd2);
    sif.rd_en_i = 1'b1;
    step();
    check("sa adv data", 32'(sif.data_o), 32'hB6);
    check("sa adv usedw", 32'(sif.usedw_o), 32'd1);
    step();
    sif.rd_en_i = 1'b0;
    check("sa empty", 32'(sif.empty_o), 32'd1);
    check("sa data hold", 32'(sif.data_o), 32'hB6);
    sif.wr_en_i = 1'b1; sif.data_i = 8'hC7;
    step();
    check("sa c7", 32'(sif.data_o), 32'hC7);
    sif.rd_en_i = 1'b1; sif.data_i = 8'hD8;
    step();
    check("sa bypass data", 32'(sif.data_o), 32'hD8);
    check("sa bypass usedw", 32'(sif.usedw_o), 32'd1);
    sif.rd_en_i = 1'b0; sif.data_i = 8'hE1;
    step();
    sif.data_i = 8'hE2;
    step();
    sif.wr_en_i = 1'b0;
    check("sa usedw 3", 32'(sif.usedw_o), 32'd3);
    sif.rd_en_i = 1'b1;
    step();
    check("sa mem e1", 32'(sif.data_o), 32'hE1);
    step();
    check("sa mem e2", 32'(sif.data_o), 32'hE2);
    step();
    sif.rd_en_i = 1'b0;
    check("sa last hold", 32'(sif.data_o), 32'hE2);
    check("sa end empty", 32'(sif.empty_o), 32'd1);

    // Wrap: three rounds of 16 writes and 16 reads, random interleave.
    last_n = 8'h77;
    for (int r = 0; r < 3; r++) begin
      wcnt = 0; rcnt = 0; iter = 0;
      while ((wcnt < 16 || rcnt < 16) && iter < 400) begin
        iter++;
        do_wr = (wcnt < 16) && ($urandom_range(0, 1) == 1);
        do_rd = (rcnt < 16) && (q.size() > 0) && ($urandom_range(0, 1) == 1);
        nif.wr_en_i = do_wr; nif.rd_en_i = do_rd;
        nif.data_i = 8'($urandom_range(0, 255));
        exp_d = nif.data_i;
        step();
        if (do_rd) begin
          last_n = q.pop_front();
          rcnt++;
          check("wrap data", 32'(nif.data_o), 32'(last_n));
        end
        if (do_wr) begin
          q.push_back(exp_d);
          wcnt++;
        end
        check("wrap usedw", 32'(nif.usedw_o), 32'(q.size()));
        check("wrap ae", 32'(nif.almost_empty_o), 32'(q.size() <= 4));
        check("wrap empty", 32'(nif.empty_o), 32'(q.size() == 0));
      end
      check("wrap round done", 32'(wcnt + rcnt), 32'd32);
    end
    nif.wr_en_i = 1'b0; nif.rd_en_i = 1'b0;

    // Flush with a same-cycle write, then reset mid-operation.
    for (int i = 0; i < 7; i++) begin
      nif.wr_en_i = 1'b1; nif.data_i = 8'(8'h30 + i);
      step();
    end
    check("pre-flush usedw", 32'(nif.usedw_o), 32'd7);
    nif.flush_i = 1'b1; nif.data_i = 8'h55;
    step();
    nif.flush_i = 1'b0; nif.wr_en_i = 1'b0;
    check("flush usedw", 32'(nif.usedw_o), 32'd0);
    check("flush empty", 32'(nif.empty_o), 32'd1);
    check("flush ae", 32'(nif.almost_empty_o), 32'd1);
    check("flush full", 32'(nif.full_o), 32'd0);
    check("flush ovf", 32'(nif.overflow_o), 32'd0);
    check("flush data held", 32'(nif.data_o), 32'(last_n));
    step();
    check("flush wr dropped", 32'(nif.usedw_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nif.wr_en_i = 1'b1; nif.data_i = 8'(8'h40 + i);
      step();
    end
    nif.wr_en_i = 1'b0;
    check("refill usedw", 32'(nif.usedw_o), 32'd3);
    nif.rd_en_i = 1'b1;
    step();
    check("refill rd", 32'(nif.data_o), 32'h40);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    nif.rd_en_i = 1'b0;
    check_reset_n("midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
